// File: rtl/mips_muldiv_if.sv
// rtl/mips_muldiv_if.sv - issue/result bundle between the controller and the mul/div unit
interface mips_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             divzero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, divzero, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, divzero, hi, lo
   );
endinterface

// File: rtl/mips_muldiv.sv
// rtl/mips_muldiv.sv - iterative radix-2 multiply/divide unit with HI/LO registers
module mips_muldiv #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH)
) (
   input logic          clk,
   input logic          reset,
   mips_muldiv_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               is_div_q, is_div_d;
   logic               neg_lo_q, neg_lo_d;
   logic               neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic               signed_op, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [2*WIDTH-1:0] mul_next, div_next, prod;
   logic [WIDTH-1:0]   quot, rem;

   assign signed_op = ~bus.op[0];
   assign a_neg     = signed_op & bus.a[WIDTH-1];
   assign b_neg     = signed_op & bus.b[WIDTH-1];
   assign a_mag     = a_neg ? -bus.a : bus.a;
   assign b_mag     = b_neg ? -bus.b : bus.b;

   // Multiply: accumulator is {partial product, remaining multiplier bits}; the carry shifts in.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: accumulator is {partial remainder, dividend bits / quotient bits}.
   assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
   assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   assign prod = neg_lo_q ? -acc_q : acc_q;
   assign quot = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  3'b100: hi_d = bus.a;
                  3'b101: lo_d = bus.a;
                  3'b000, 3'b001: begin
                     acc_d    = {{WIDTH{1'b0}}, b_mag};
                     opnd_d   = a_mag;
                     is_div_d = 1'b0;
                     neg_lo_d = a_neg ^ b_neg;
                     neg_hi_d = 1'b0;
                     cnt_d    = CW'(WIDTH - 1);
                     state_d  = CALC;
                  end
                  3'b010, 3'b011: begin
                     if (bus.b == '0) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                     end else begin
                        acc_d    = {{WIDTH{1'b0}}, a_mag};
                        opnd_d   = b_mag;
                        is_div_d = 1'b1;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                        cnt_d    = CW'(WIDTH - 1);
                        state_d  = CALC;
                     end
                  end
                  default: ;
               endcase
            end
         end
         CALC: begin
            acc_d = is_div_q ? div_next : mul_next;
            if (cnt_q == '0) state_d = FIX;
            else             cnt_d   = cnt_q - CW'(1);
         end
         FIX: begin
            if (is_div_q) begin
               hi_d = rem;
               lo_d = quot;
            end else begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = done_q;
   assign bus.divzero = dz_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
endmodule

// File: tb/tb_mips_muldiv.sv
// tb/tb_mips_muldiv.sv - randomized and directed checks of mips_muldiv against an arithmetic model
module tb_mips_muldiv;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mips_muldiv_if #(.WIDTH(W)) bus ();

   mips_muldiv #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] hi_m = '0;
   logic [W-1:0] lo_m = '0;

   task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: 64-bit integer arithmetic; SV / and % truncate toward zero.
   task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
      longint sa, sb;
      logic [63:0] p;
      h  = hi_m;
      l  = lo_m;
      dz = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
         3'd1: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
         3'd2: if (b == 0) dz = 1'b1;
               else begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
         3'd3: if (b == 0) dz = 1'b1;
               else begin l = a / b; h = a % b; end
         3'd4: h = a;
         3'd5: l = a;
         default: ;
      endcase
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] eh, el;
      logic edz;
      int cyc;
      model(op, a, b, eh, el, edz);
      issue(op, a, b);
      if (op >= 3'd4 || edz) begin
         expect_eq({tag, "_busy"}, bus.busy, 0);
         expect_eq({tag, "_done"}, bus.done, edz);
         expect_eq({tag, "_dz"}, bus.divzero, edz);
         expect_eq({tag, "_hi"}, bus.hi, eh);
         expect_eq({tag, "_lo"}, bus.lo, el);
      end else begin
         expect_eq({tag, "_oldhi"}, bus.hi, hi_m);
         expect_eq({tag, "_oldlo"}, bus.lo, lo_m);
         cyc = 0;
         for (int t = 0; t < 100 && !bus.done; t++) begin
            if (bus.busy) cyc++;
            @(negedge clk);
         end
         expect_eq({tag, "_cycles"}, cyc, W + 1);
         expect_eq({tag, "_done"}, bus.done, 1);
         expect_eq({tag, "_busy"}, bus.busy, 0);
         expect_eq({tag, "_dz"}, bus.divzero, 0);
         expect_eq({tag, "_hi"}, bus.hi, eh);
         expect_eq({tag, "_lo"}, bus.lo, el);
      end
      hi_m = eh;
      lo_m = el;
      @(negedge clk);
      expect_eq({tag, "_pulse"}, {bus.done, bus.divzero}, 0);
   endtask

   initial begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      int cyc;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      reset     = 1'b1;
      repeat (2) @(negedge clk);
      expect_eq("rst_state", {bus.busy, bus.done, bus.divzero}, 0);
      expect_eq("rst_hilo", {bus.hi, bus.lo}, 0);
      reset = 1'b0;

      do_op("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'd5);
      do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("mult_m1xm1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
      do_op("divu_100_7", 3'd3, 32'd100, 32'd7);
      do_op("div_minneg", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op("mthi_11", 3'd4, 32'h11, 32'h0);
      do_op("mtlo_22", 3'd5, 32'h22, 32'h0);
      do_op("div_by0", 3'd2, 32'd5, 32'd0);
      do_op("mthi", 3'd4, 32'hABCD_0000, 32'h0);
      do_op("mtlo", 3'd5, 32'h1234, 32'h0);
      do_op("nop6", 3'd6, 32'h5555, 32'h7777);

      // MTHI issued while busy must be dropped.
      issue(3'd1, 32'd3, 32'd4);
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD;
      @(negedge clk);
      bus.start = 1'b0;
      expect_eq("ign_hi_mid", bus.hi, 32'hABCD_0000);
      cyc = 0;
      while (!bus.done && cyc < 100) begin cyc++; @(negedge clk); end
      expect_eq("ign_done", bus.done, 1);
      expect_eq("ign_hilo", {bus.hi, bus.lo}, {32'd0, 32'd12});
      hi_m = 32'd0; lo_m = 32'd12;

      // Reset mid-divide aborts and clears HI/LO.
      issue(3'd3, 32'd100, 32'd7);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      expect_eq("rst_mid_state", {bus.busy, bus.done, bus.divzero}, 0);
      expect_eq("rst_mid_hilo", {bus.hi, bus.lo}, 0);
      hi_m = '0; lo_m = '0;
      do_op("post_rst_mul", 3'd1, 32'd2, 32'd3);

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         do_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
